// File: rtl/frame_sched_pkg.sv
// ============================================================================
// frame_sched_pkg : shared state encoding and default sizing for frame_scheduler
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

package frame_sched_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_WIN = 3'd1,
        STREAM   = 3'd2,
        FEAT     = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam int FRAME_LEN_DEF  = 64;
    localparam int NUM_FRAMES_DEF = 32;
    localparam int TIMEOUT_DEF    = 255;

    // Width of an index over n items; never collapses to zero bits.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/frame_sched_cnt.sv
// ============================================================================
// frame_sched_cnt : per-frame sample counter and inter-strobe inactivity timer
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_sched_cnt #(
    parameter int FRAME_LEN = 64,
    parameter int TIMEOUT   = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic ser_valid,
    output logic term,
    output logic timeout
);

    localparam int SW = $clog2(FRAME_LEN) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [SW-1:0] SAMPLE_LAST = SW'(FRAME_LEN - 1);
    localparam logic [SW-1:0] SAMPLE_MAX  = SW'(FRAME_LEN);
    localparam logic [TW-1:0] TIME_LIM    = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TIME_MAX    = TW'(TIMEOUT);

    logic [SW-1:0] sample_cnt;
    logic [TW-1:0] tcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt <= '0;
            tcnt       <= '0;
        end else if (clr) begin
            sample_cnt <= '0;
            tcnt       <= '0;
        end else if (en) begin
            if (ser_valid) begin
                if (sample_cnt < SAMPLE_MAX)
                    sample_cnt <= sample_cnt + SW'(1);
                tcnt <= '0;
            end else if (tcnt != TIME_MAX) begin
                tcnt <= tcnt + TW'(1);
            end
        end
    end

    // Both flags fire on the edge that would complete the condition, so the
    // FSM reacts on that same edge rather than one cycle later.
    assign term    = en & ser_valid & (sample_cnt == SAMPLE_LAST);
    assign timeout = en & ~ser_valid & (tcnt >= TIME_LIM);

endmodule

`default_nettype wire

// File: rtl/frame_scheduler.sv
// ============================================================================
// frame_scheduler : sequences window streaming and feature extraction per frame
// Optional statistics ports enabled by defining FRAME_SCHED_STATS_EN.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_scheduler
    import frame_sched_pkg::*;
#(
    parameter int FRAME_LEN  = FRAME_LEN_DEF,
    parameter int NUM_FRAMES = NUM_FRAMES_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF,
    parameter int FIDX_W     = idx_width(NUM_FRAMES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              win_avail,
    output logic              win_ready,
    input  logic              ser_valid,
    input  logic              feat_busy,
    output logic              feat_start,
    input  logic              feat_done,
    output logic [FIDX_W-1:0] frame_idx,
    output logic              busy,
    output logic              utt_done,
    output logic              err_timeout
`ifdef FRAME_SCHED_STATS_EN
    ,
    output logic [15:0]       frames_total,
    output logic [15:0]       stall_cycles
`endif
);

    localparam logic [FIDX_W-1:0] LAST_FRAME = FIDX_W'(NUM_FRAMES - 1);

    state_t            state_q;
    state_t            state_d;
    logic              win_ready_d;
    logic              feat_start_d;
    logic              utt_done_d;
    logic [FIDX_W-1:0] frame_idx_d;
    logic              err_d;
    logic              cnt_clr;
    logic              feat_accept;
    logic              cnt_term;
    logic              cnt_timeout;

    frame_sched_cnt #(
        .FRAME_LEN (FRAME_LEN),
        .TIMEOUT   (TIMEOUT)
    ) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr       (cnt_clr),
        .en        (state_q == STREAM),
        .ser_valid (ser_valid),
        .term      (cnt_term),
        .timeout   (cnt_timeout)
    );

    always_comb begin
        state_d      = state_q;
        win_ready_d  = win_ready;
        feat_start_d = 1'b0;
        utt_done_d   = 1'b0;
        frame_idx_d  = frame_idx;
        err_d        = err_timeout;
        cnt_clr      = 1'b0;
        feat_accept  = 1'b0;
        if (abort) begin
            state_d     = IDLE;
            win_ready_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d     = WAIT_WIN;
                        frame_idx_d = '0;
                        err_d       = 1'b0;
                    end
                end
                WAIT_WIN: begin
                    if (win_avail && !feat_busy) begin
                        state_d     = STREAM;
                        win_ready_d = 1'b1;
                        cnt_clr     = 1'b1;
                    end
                end
                STREAM: begin
                    if (cnt_term) begin
                        state_d      = FEAT;
                        win_ready_d  = 1'b0;
                        feat_start_d = 1'b1;
                    end else if (cnt_timeout) begin
                        state_d     = IDLE;
                        win_ready_d = 1'b0;
                        err_d       = 1'b1;
                    end
                end
                FEAT: begin
                    // A done coinciding with our own start pulse belongs to no frame.
                    if (feat_done && !feat_start) begin
                        feat_accept = 1'b1;
                        if (frame_idx == LAST_FRAME) begin
                            state_d    = DONE;
                            utt_done_d = 1'b1;
                        end else begin
                            state_d     = WAIT_WIN;
                            frame_idx_d = frame_idx + FIDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d     = IDLE;
                    win_ready_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            win_ready   <= 1'b0;
            feat_start  <= 1'b0;
            utt_done    <= 1'b0;
            busy        <= 1'b0;
            frame_idx   <= '0;
            err_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_ready   <= win_ready_d;
            feat_start  <= feat_start_d;
            utt_done    <= utt_done_d;
            busy        <= (state_d != IDLE);
            frame_idx   <= frame_idx_d;
            err_timeout <= err_d;
        end
    end

`ifdef FRAME_SCHED_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frames_total <= '0;
            stall_cycles <= '0;
        end else begin
            if (feat_accept)
                frames_total <= frames_total + 16'd1;
            if ((state_q == WAIT_WIN) && win_avail && feat_busy && (stall_cycles != 16'hFFFF))
                stall_cycles <= stall_cycles + 16'd1;
        end
    end
`else
    logic unused_stats;
    assign unused_stats = feat_accept;
`endif

endmodule

`default_nettype wire

// File: tb/tb_frame_scheduler.sv
// ============================================================================
// tb_frame_scheduler : directed self-checking bench for frame_scheduler
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frame_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        win_avail;
    logic        win_ready;
    logic        ser_valid;
    logic        feat_busy;
    logic        feat_start;
    logic        feat_done;
    logic [0:0]  frame_idx;
    logic        busy;
    logic        utt_done;
    logic        err_timeout;
`ifdef FRAME_SCHED_STATS_EN
    logic [15:0] frames_total;
    logic [15:0] stall_cycles;
`endif

    int checks = 0;
    int errors = 0;
    logic flag;

    always #5 clk = ~clk;

    frame_scheduler #(
        .FRAME_LEN  (64),
        .NUM_FRAMES (2),
        .TIMEOUT    (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .win_avail   (win_avail),
        .win_ready   (win_ready),
        .ser_valid   (ser_valid),
        .feat_busy   (feat_busy),
        .feat_start  (feat_start),
        .feat_done   (feat_done),
        .frame_idx   (frame_idx),
        .busy        (busy),
        .utt_done    (utt_done),
        .err_timeout (err_timeout)
`ifdef FRAME_SCHED_STATS_EN
        ,
        .frames_total(frames_total),
        .stall_cycles(stall_cycles)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Enter STREAM from WAIT_WIN and deliver a full back-to-back window.
    task automatic stream_frame();
        tick();
        ser_valid = 1'b1;
        repeat (64) tick();
        ser_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; win_avail = 1'b0;
        ser_valid = 1'b0; feat_busy = 1'b0; feat_done = 1'b0;
        tick(); tick();
        check("rst_win_ready", 32'(win_ready), 32'd0);
        check("rst_feat_start", 32'(feat_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_utt_done", 32'(utt_done), 32'd0);
        check("rst_frame_idx", 32'(frame_idx), 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);
        rst = 1'b0;
        tick();

        // Nominal frame 0: back-to-back strobes, feat_done 5 cycles after feat_start
        start = 1'b1; win_avail = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("wait_win_ready_low", 32'(win_ready), 32'd0);
        tick();
        check("win_ready_latency", 32'(win_ready), 32'd1);
        flag = 1'b0;
        for (int i = 0; i < 64; i++) begin
            ser_valid = 1'b1;
            tick();
            if (i < 63 && feat_start) flag = 1'b1;
        end
        ser_valid = 1'b0;
        check("f0_early_feat_start", 32'(flag), 32'd0);
        check("f0_feat_start", 32'(feat_start), 32'd1);
        check("f0_win_ready_drop", 32'(win_ready), 32'd0);
        tick();
        check("f0_feat_start_pulse", 32'(feat_start), 32'd0);
        repeat (3) tick();
        feat_done = 1'b1;
        tick();
        feat_done = 1'b0;
        check("f0_frame_idx", 32'(frame_idx), 32'd1);
        check("f0_no_utt_done", 32'(utt_done), 32'd0);
        check("f0_busy", 32'(busy), 32'd1);

        // Frame 1: gappy stream, one strobe every third cycle
        tick();
        check("f1_win_ready", 32'(win_ready), 32'd1);
        flag = 1'b0;
        for (int i = 0; i < 64; i++) begin
            ser_valid = 1'b0;
            tick();
            if (!win_ready || feat_start) flag = 1'b1;
            tick();
            if (!win_ready || feat_start) flag = 1'b1;
            ser_valid = 1'b1;
            tick();
            if (i < 63 && (!win_ready || feat_start)) flag = 1'b1;
        end
        ser_valid = 1'b0;
        check("gappy_hold", 32'(flag), 32'd0);
        check("gappy_feat_start", 32'(feat_start), 32'd1);
        feat_done = 1'b1;
        tick();
        check("done_with_start_ignored", 32'(utt_done), 32'd0);
        tick();
        feat_done = 1'b0;
        check("utt_done_pulse", 32'(utt_done), 32'd1);
        check("utt_done_frame_idx", 32'(frame_idx), 32'd1);
        tick();
        check("utt_done_cleared", 32'(utt_done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        win_avail = 1'b0;

        // Backpressure: feature stage busy while a window is available
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_frame_idx", 32'(frame_idx), 32'd0);
        win_avail = 1'b1; feat_busy = 1'b1;
        flag = 1'b0;
        repeat (7) begin
            tick();
            if (win_ready) flag = 1'b1;
        end
        check("bp_win_ready_low", 32'(flag), 32'd0);
        feat_busy = 1'b0;
        tick();
        check("bp_release", 32'(win_ready), 32'd1);
`ifdef FRAME_SCHED_STATS_EN
        check("stall_cycles", 32'(stall_cycles), 32'd7);
        check("frames_total", 32'(frames_total), 32'd2);
`endif

        // Timeout: 20 strobes then silence
        ser_valid = 1'b1;
        repeat (20) tick();
        ser_valid = 1'b0;
        repeat (9) tick();
        check("to_not_yet_err", 32'(err_timeout), 32'd0);
        check("to_not_yet_win", 32'(win_ready), 32'd1);
        tick();
        check("to_err", 32'(err_timeout), 32'd1);
        check("to_win_ready", 32'(win_ready), 32'd0);
        check("to_idle", 32'(busy), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("to_err_cleared", 32'(err_timeout), 32'd0);
        check("to_restart_busy", 32'(busy), 32'd1);

        // Abort in frame 1 after 30 strobes, with start pulses while busy
        stream_frame();
        tick();
        feat_done = 1'b1;
        tick();
        feat_done = 1'b0;
        tick();
        ser_valid = 1'b1; start = 1'b1;
        repeat (30) tick();
        ser_valid = 1'b0; start = 1'b0;
        check("pre_abort_win_ready", 32'(win_ready), 32'd1);
        check("pre_abort_frame_idx", 32'(frame_idx), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_win_ready", 32'(win_ready), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_feat_start", 32'(feat_start), 32'd0);
        check("abort_frame_idx", 32'(frame_idx), 32'd1);
        tick();
        check("abort_stays_idle", 32'(busy), 32'd0);
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("abort_beats_start", 32'(busy), 32'd0);

        // Asynchronous reset mid-FEAT of frame 1
        start = 1'b1;
        tick();
        start = 1'b0;
        stream_frame();
        tick();
        feat_done = 1'b1;
        tick();
        feat_done = 1'b0;
        stream_frame();
        tick();
        check("pre_rst_busy", 32'(busy), 32'd1);
        check("pre_rst_frame_idx", 32'(frame_idx), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_frame_idx", 32'(frame_idx), 32'd0);
        check("arst_win_ready", 32'(win_ready), 32'd0);
        check("arst_feat_start", 32'(feat_start), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_utt_done", 32'(utt_done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
